// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, release handshake and hold-time watchdog.
// Latency: grant registered one edge after req seen in IDLE; release/revoke drops grant_valid after the sampling edge.
// Backpressure: the owner holds the grant until release_in, dropping req, or the watchdog; other requests wait for IDLE.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req[3:0]    level-sensitive request, bit i belongs to requester i
//   release_in  owner done, only looked at while grant_valid=1
//   grant_idx   registered index of the current/last owner (drives the 2-to-4 decoder select)
//   grant_valid registered, grant_idx is a live grant
//   timeout     one-cycle pulse when the watchdog revokes a grant
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       release_in,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  // Counter value on the last permitted hold cycle; unused when the watchdog is disabled.
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    last_idx;
  logic [CW-1:0] hold_cnt;

  logic [1:0]    pick;
  logic          any_req;
  logic          owner_rel;
  logic          wd_fire;

  // Rotating priority: scan offsets 4 down to 1 so the smallest offset from
  // last_idx that is requesting is the one left in pick. Offset 4 is last_idx
  // itself, i.e. the previous owner only wins when nobody else asks.
  always_comb begin
    pick = last_idx;
    for (int k = 4; k >= 1; k--) begin
      if (req[last_idx + 2'(k)]) begin
        pick = last_idx + 2'(k);
      end
    end
  end

  assign any_req   = |req;
  // The owner dropping its request is treated exactly like an explicit release.
  assign owner_rel = release_in | ~req[grant_idx];
  assign wd_fire   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      last_idx    <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (any_req) begin
            grant_idx   <= pick;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (owner_rel || wd_fire) begin
            grant_valid <= 1'b0;
            last_idx    <= grant_idx;
            // A release in the same cycle as expiry wins: no timeout pulse.
            timeout     <= wd_fire & ~owner_rel;
            state       <= IDLE;
          end else begin
            timeout <= 1'b0;
            if (hold_cnt != '1) begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          timeout     <= 1'b0;
        end
      endcase
    end
  end

endmodule
